// File: rtl/elastic_skp_buffer.sv
// Single-clock elastic buffer between symbol decoder and status encoder.
// Absorbs rate mismatch by dropping or duplicating SKPs inside SKP ordered sets.
module elastic_skp_buffer #(
    parameter int DEPTH     = 16,
    parameter int FILL      = 8,
    parameter int HI_THRESH = 12,
    parameter int LO_THRESH = 4
) (
    input  logic                   CLK,
    input  logic                   Rst,
    input  logic [7:0]             Data_In,
    input  logic                   DataK_In,
    input  logic                   Wr_Valid,
    output logic [7:0]             Data_Out,
    output logic                   DataK_Out,
    output logic                   Data_Valid_Out,
    output logic                   Overflow,
    output logic                   Underflow,
    output logic                   Skp_Added,
    output logic                   Skp_Removed,
    output logic [$clog2(DEPTH):0] Fill_Level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] FILL_C  = CW'(FILL);
    localparam logic [CW-1:0] HI_C    = CW'(HI_THRESH);
    localparam logic [CW-1:0] LO_C    = CW'(LO_THRESH);
    localparam logic [8:0]    SYM_COM = 9'h1BC;
    localparam logic [8:0]    SYM_SKP = 9'h11C;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_active_q, rd_active_d;
    logic          in_os_q, in_os_d;
    logic [1:0]    skp_cnt_q, skp_cnt_d;
    logic          rm_done_q, rm_done_d;
    logic          add_done_q, add_done_d;
    logic [8:0]    dout_q, dout_d;
    logic          dvalid_q, dvalid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          added_q, added_d;
    logic          removed_q, removed_d;

    logic [8:0] wr_sym, rd_sym;
    logic       pop, insert, rd_eff, remove, wr_eff;

    assign wr_sym = {DataK_In, Data_In};
    assign rd_sym = mem[rd_ptr_q];

    // All decisions use the registered count of the current cycle.
    assign pop    = (rd_active_q || (count_q >= FILL_C)) && (count_q != '0);
    assign insert = pop && (rd_sym == SYM_SKP) && (count_q <= LO_C) && !add_done_q;
    assign rd_eff = pop && !insert;
    assign remove = Wr_Valid && (wr_sym == SYM_SKP) && in_os_q && (skp_cnt_q != 2'd0)
                    && !rm_done_q && (count_q >= HI_C);
    assign ovf_d  = Wr_Valid && !remove && (count_q == FULL_C) && !rd_eff;
    assign wr_eff = Wr_Valid && !remove && !ovf_d;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(wr_eff);
        rd_ptr_d    = rd_ptr_q + AW'(rd_eff);
        count_d     = count_q + CW'(wr_eff) - CW'(rd_eff);
        rd_active_d = rd_active_q;
        in_os_d     = in_os_q;
        skp_cnt_d   = skp_cnt_q;
        rm_done_d   = rm_done_q || remove;
        add_done_d  = add_done_q;
        dout_d      = dout_q;
        dvalid_d    = pop;
        udf_d       = rd_active_q && (count_q == '0);
        added_d     = insert;
        removed_d   = remove;

        if (udf_d) begin
            rd_active_d = 1'b0;
        end else if (count_q >= FILL_C) begin
            rd_active_d = 1'b1;
        end

        if (pop) begin
            dout_d = rd_sym;
        end
        // A duplicated SKP is re-popped normally; the next COM re-arms insertion.
        if (insert) begin
            add_done_d = 1'b1;
        end else if (rd_eff && (rd_sym == SYM_COM)) begin
            add_done_d = 1'b0;
        end

        if (Wr_Valid) begin
            if (wr_sym == SYM_COM) begin
                in_os_d   = 1'b1;
                skp_cnt_d = 2'd0;
                rm_done_d = 1'b0;
            end else if (wr_sym == SYM_SKP) begin
                if (skp_cnt_q != 2'd3) begin
                    skp_cnt_d = skp_cnt_q + 2'd1;
                end
            end else begin
                in_os_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_eff) begin
            mem[wr_ptr_q] <= wr_sym;
        end
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_active_q <= 1'b0;
            in_os_q     <= 1'b0;
            skp_cnt_q   <= 2'd0;
            rm_done_q   <= 1'b0;
            add_done_q  <= 1'b0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            added_q     <= 1'b0;
            removed_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_active_q <= rd_active_d;
            in_os_q     <= in_os_d;
            skp_cnt_q   <= skp_cnt_d;
            rm_done_q   <= rm_done_d;
            add_done_q  <= add_done_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            added_q     <= added_d;
            removed_q   <= removed_d;
        end
    end

    assign Data_Out       = dout_q[7:0];
    assign DataK_Out      = dout_q[8];
    assign Data_Valid_Out = dvalid_q;
    assign Overflow       = ovf_q;
    assign Underflow      = udf_q;
    assign Skp_Added      = added_q;
    assign Skp_Removed    = removed_q;
    assign Fill_Level     = count_q;
endmodule

// File: tb/tb_elastic_skp_buffer.sv
// Bench for elastic_skp_buffer: three instances differing only in FILL (8, 12, 17)
// run on shared stimulus and are compared against a queue-based reference model.
module tb_elastic_skp_buffer;
    localparam int NI      = 3;
    localparam int DEPTH_P = 16;
    localparam int HI_P    = 12;
    localparam int LO_P    = 4;
    localparam logic [8:0] COM = 9'h1BC;
    localparam logic [8:0] SKP = 9'h11C;

    logic       CLK   = 1'b0;
    logic       Rst   = 1'b1;
    logic [7:0] din   = 8'h00;
    logic       dk_in = 1'b0;
    logic       wv    = 1'b0;

    logic [7:0] dout [NI];
    logic       dko  [NI];
    logic       dvo  [NI];
    logic       ovfo [NI];
    logic       udfo [NI];
    logic       sao  [NI];
    logic       sro  [NI];
    logic [4:0] flo  [NI];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        elastic_skp_buffer #(
            .DEPTH(DEPTH_P),
            .FILL(gi == 0 ? 8 : (gi == 1 ? 12 : 17)),
            .HI_THRESH(HI_P),
            .LO_THRESH(LO_P)
        ) u_dut (
            .CLK(CLK),
            .Rst(Rst),
            .Data_In(din),
            .DataK_In(dk_in),
            .Wr_Valid(wv),
            .Data_Out(dout[gi]),
            .DataK_Out(dko[gi]),
            .Data_Valid_Out(dvo[gi]),
            .Overflow(ovfo[gi]),
            .Underflow(udfo[gi]),
            .Skp_Added(sao[gi]),
            .Skp_Removed(sro[gi]),
            .Fill_Level(flo[gi])
        );
    end

    // Reference model: buffer contents as a queue, flags rebuilt from the rules.
    logic [8:0] mq [NI][$];
    bit         m_ra [NI];
    bit         m_inos [NI];
    bit         m_rmd [NI];
    bit         m_add [NI];
    int         m_sc [NI];
    logic [7:0] m_do [NI];
    bit         m_dk [NI];
    bit         m_dv [NI];
    bit         m_ovf [NI];
    bit         m_udf [NI];
    bit         m_sa [NI];
    bit         m_sr [NI];

    function automatic int fill_of(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 12 : 17);
    endfunction

    task automatic model_reset(input int i);
        mq[i].delete();
        m_ra[i] = 0; m_inos[i] = 0; m_rmd[i] = 0; m_add[i] = 0; m_sc[i] = 0;
        m_do[i] = 8'h00; m_dk[i] = 0; m_dv[i] = 0;
        m_ovf[i] = 0; m_udf[i] = 0; m_sa[i] = 0; m_sr[i] = 0;
    endtask

    task automatic model_step(input int i);
        int cnt;
        bit pop, rde, rem;
        logic [8:0] head, sym;
        if (Rst) begin
            model_reset(i);
        end else begin
            cnt = mq[i].size();
            rde = 0;
            m_sa[i] = 0; m_udf[i] = 0; m_sr[i] = 0; m_ovf[i] = 0;
            pop = (m_ra[i] || cnt >= fill_of(i)) && cnt != 0;
            m_dv[i] = pop;
            if (pop) begin
                head = mq[i][0];
                m_do[i] = head[7:0];
                m_dk[i] = head[8];
                if (head == SKP && cnt <= LO_P && !m_add[i]) begin
                    m_sa[i] = 1;
                    m_add[i] = 1;
                end else begin
                    rde = 1;
                    if (head == COM) m_add[i] = 0;
                    void'(mq[i].pop_front());
                end
            end
            if (m_ra[i] && cnt == 0) begin
                m_udf[i] = 1;
                m_ra[i] = 0;
            end else if (cnt >= fill_of(i)) begin
                m_ra[i] = 1;
            end
            if (wv) begin
                sym = {dk_in, din};
                rem = (sym == SKP) && m_inos[i] && m_sc[i] >= 1 && !m_rmd[i] && cnt >= HI_P;
                if (sym == COM) begin
                    m_inos[i] = 1; m_sc[i] = 0; m_rmd[i] = 0;
                end else if (sym == SKP) begin
                    if (m_sc[i] < 3) m_sc[i]++;
                end else begin
                    m_inos[i] = 0;
                end
                if (rem) begin
                    m_sr[i] = 1;
                    m_rmd[i] = 1;
                end else if (cnt == DEPTH_P && !rde) begin
                    m_ovf[i] = 1;
                end else begin
                    mq[i].push_back(sym);
                end
            end
        end
    endtask

    function automatic logic [18:0] obs(input int i);
        return {dvo[i], dko[i], dout[i], ovfo[i], udfo[i], sao[i], sro[i], flo[i]};
    endfunction

    function automatic logic [18:0] expv(input int i);
        return {m_dv[i], m_dk[i], m_do[i], m_ovf[i], m_udf[i], m_sa[i], m_sr[i], 5'(mq[i].size())};
    endfunction

    task automatic tick();
        for (int i = 0; i < NI; i++) model_step(i);
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic put(input logic v, input logic [8:0] s);
        wv    = v;
        dk_in = s[8];
        din   = s[7:0];
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        put(1'b0, 9'h000);
        tick();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        put(1'b1, COM);
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (obs(i) !== 19'h0) begin
                n_fail++;
                $display("FAIL reset inst%0d: got {dv,k,d,ovf,udf,add,rm,fill}=%h, expected 00000", i, obs(i));
            end
        end
        Rst = 1'b0;
        put(1'b0, 9'h000);
    endtask

    task automatic test_fill_latency();
        int first = -1;
        logic [7:0] fd = 8'hFF;
        do_reset();
        for (int t = 1; t <= 24; t++) begin
            put(1'b1, {1'b0, 8'(t - 1)});
            tick();
            n_tests++;
            if (obs(0) !== expv(0)) begin
                n_fail++;
                $display("FAIL latency cyc=%0d: got %h, expected %h", cyc, obs(0), expv(0));
            end
            if (dvo[0] && first < 0) begin
                first = t;
                fd = dout[0];
            end
        end
        put(1'b0, 9'h000);
        n_tests++;
        if (first - 1 != 8) begin
            n_fail++;
            $display("FAIL latency_edges: got %0d, expected 8", first - 1);
        end
        n_tests++;
        if (fd !== 8'h00) begin
            n_fail++;
            $display("FAIL latency_first_data: got %h, expected 00", fd);
        end
        n_tests++;
        if (flo[0] !== 5'd8) begin
            n_fail++;
            $display("FAIL latency_fill: got %0d, expected 8", flo[0]);
        end
    endtask

    task automatic test_skp_remove();
        int n_rm = 0;
        int n_skp = 0;
        logic [8:0] s;
        do_reset();
        for (int t = 0; t < 36; t++) begin
            if (t == 14) s = COM;
            else if (t >= 15 && t <= 17) s = SKP;
            else s = {1'b0, 8'(8'h20 + t)};
            put(1'b1, s);
            tick();
            n_tests++;
            if (obs(1) !== expv(1)) begin
                n_fail++;
                $display("FAIL skp_remove cyc=%0d: got %h, expected %h", cyc, obs(1), expv(1));
            end
            if (sro[1]) n_rm++;
            if (dvo[1] && {dko[1], dout[1]} == SKP) n_skp++;
        end
        put(1'b0, 9'h000);
        n_tests++;
        if (n_rm != 1) begin
            n_fail++;
            $display("FAIL skp_removed_pulses: got %0d, expected 1", n_rm);
        end
        n_tests++;
        if (n_skp != 2) begin
            n_fail++;
            $display("FAIL skp_remove_out_count: got %0d, expected 2", n_skp);
        end
    endtask

    task automatic test_skp_insert();
        int n_sa = 0;
        int n_skp = 0;
        int pos = 0;
        int sa_pos = -1;
        logic [8:0] s;
        do_reset();
        for (int t = 0; t < 32; t++) begin
            if (t < 4) put(1'b1, {1'b0, 8'(8'h50 + t)});
            else if (t == 4) put(1'b1, COM);
            else if (t < 8) put(1'b1, SKP);
            else if (t < 12) put(1'b0, 9'h000);
            else put(1'b1, {1'b0, 8'(8'h60 + t)});
            tick();
            n_tests++;
            if (obs(0) !== expv(0)) begin
                n_fail++;
                $display("FAIL skp_insert cyc=%0d: got %h, expected %h", cyc, obs(0), expv(0));
            end
            s = {dko[0], dout[0]};
            if (dvo[0]) begin
                if (s == COM) begin
                    pos = 0;
                end else if (s == SKP) begin
                    pos++;
                    n_skp++;
                    if (sao[0]) sa_pos = pos;
                end
            end
            if (sao[0]) n_sa++;
        end
        put(1'b0, 9'h000);
        n_tests++;
        if (n_skp != 4) begin
            n_fail++;
            $display("FAIL skp_insert_out_count: got %0d, expected 4", n_skp);
        end
        n_tests++;
        if (n_sa != 1) begin
            n_fail++;
            $display("FAIL skp_added_pulses: got %0d, expected 1", n_sa);
        end
        n_tests++;
        if (sa_pos != 1) begin
            n_fail++;
            $display("FAIL skp_added_position: got %0d, expected 1", sa_pos);
        end
    endtask

    task automatic test_overflow();
        int n_ovf = 0;
        do_reset();
        for (int t = 0; t < 18; t++) begin
            if (t < 17) put(1'b1, {1'b0, 8'($urandom)});
            else put(1'b0, 9'h000);
            tick();
            n_tests++;
            if (obs(2) !== expv(2)) begin
                n_fail++;
                $display("FAIL overflow cyc=%0d: got %h, expected %h", cyc, obs(2), expv(2));
            end
            if (ovfo[2]) n_ovf++;
        end
        n_tests++;
        if (n_ovf != 1) begin
            n_fail++;
            $display("FAIL overflow_pulses: got %0d, expected 1", n_ovf);
        end
        n_tests++;
        if (flo[2] !== 5'd16) begin
            n_fail++;
            $display("FAIL overflow_fill: got %0d, expected 16", flo[2]);
        end
    endtask

    task automatic test_underflow();
        int n_dv = 0;
        int n_udf = 0;
        do_reset();
        for (int t = 0; t < 31; t++) begin
            if (t < 8 || (t >= 22 && t < 28)) put(1'b1, {1'b0, 8'(8'h70 + t)});
            else put(1'b0, 9'h000);
            tick();
            n_tests++;
            if (obs(0) !== expv(0)) begin
                n_fail++;
                $display("FAIL underflow cyc=%0d: got %h, expected %h", cyc, obs(0), expv(0));
            end
            if (dvo[0]) n_dv++;
            if (udfo[0]) n_udf++;
        end
        put(1'b0, 9'h000);
        n_tests++;
        if (n_dv != 8) begin
            n_fail++;
            $display("FAIL underflow_valid_count: got %0d, expected 8", n_dv);
        end
        n_tests++;
        if (n_udf != 1) begin
            n_fail++;
            $display("FAIL underflow_pulses: got %0d, expected 1", n_udf);
        end
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        logic [7:0] first = 8'h00;
        bit seen = 0;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            put(1'b1, {1'b0, 8'(8'h40 + t)});
            tick();
        end
        n_tests++;
        if (flo[1] !== 5'd10) begin
            n_fail++;
            $display("FAIL midreset_fill_before: got %0d, expected 10", flo[1]);
        end
        Rst = 1'b1;
        put(1'b1, 9'h0AA);
        tick();
        Rst = 1'b0;
        n_tests++;
        if (obs(1) !== 19'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h, expected 00000", obs(1));
        end
        for (int t = 0; t < 16; t++) begin
            put(1'b1, {1'b0, 8'(8'h80 + t)});
            tick();
            n_tests++;
            if (obs(1) !== expv(1)) begin
                n_fail++;
                $display("FAIL midreset cyc=%0d: got %h, expected %h", cyc, obs(1), expv(1));
            end
            if (dvo[1]) begin
                if (dout[1] < 8'h80) bad++;
                if (!seen) begin
                    seen = 1;
                    first = dout[1];
                end
            end
        end
        put(1'b0, 9'h000);
        n_tests++;
        if (bad != 0 || !seen || first !== 8'h80) begin
            n_fail++;
            $display("FAIL midreset_stale: got stale=%0d first=%h, expected stale=0 first=80", bad, first);
        end
    endtask

    task automatic test_random();
        logic [8:0] pend[$];
        int pct = 100;
        int n;
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            if (t % 250 == 0) pct = ((t / 250) % 2 == 0) ? 100 : 55;
            if ($urandom_range(99) < pct) begin
                if (pend.size() == 0) begin
                    if ($urandom_range(5) == 0) begin
                        pend.push_back(COM);
                        n = $urandom_range(1, 3);
                        for (int k = 0; k < n; k++) pend.push_back(SKP);
                    end else begin
                        pend.push_back({($urandom_range(7) == 0), 8'($urandom)});
                    end
                end
                put(1'b1, pend.pop_front());
            end else begin
                put(1'b0, 9'h000);
            end
            tick();
            for (int i = 0; i < NI; i++) begin
                n_tests++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc=%0d: got %h, expected %h", i, cyc, obs(i), expv(i));
                end
            end
        end
        put(1'b0, 9'h000);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) model_reset(i);
        test_reset();
        test_fill_latency();
        test_skp_remove();
        test_skp_insert();
        test_overflow();
        test_underflow();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
